// File: rtl/sn_pop_counter.sv
// Parallel counter: Batcher odd-even merge network sorts in_data into a thermometer code, then encodes the count. Optional out_thermo port via SN_PC_THERMO_EN.
// Latency: R+1 cycles (R = ceil(D/REG_EVERY) register ranks plus the output register); one word per cycle.
// Backpressure: global stall when out_valid & ~out_ready freezes every rank and the output; in_ready = ~stall.
`timescale 1ns/1ps

module sn_pop_counter #(
    parameter int N         = 7,
    parameter int REG_EVERY = 2,
    localparam int CW       = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_count
`ifdef SN_PC_THERMO_EN
    ,
    output logic [N-1:0]  out_thermo
`endif
);

    // Network geometry: width rounded up to a power of two, depth k(k+1)/2.
    localparam int K = $clog2(N);
    localparam int P = 1 << K;
    localparam int D = (K * (K + 1)) / 2;

    // Merge size p of comparator level lv (levels run p=1; p=2,k=2,1; p=4,k=4,2,1; ...).
    function automatic int lvl_p(input int lv);
        int base;
        int res;
        base = 0;
        res  = 1;
        for (int x = 0; x < 8; x++) begin
            if (lv >= base && lv < base + x + 1) begin
                res = 1 << x;
            end
            base = base + x + 1;
        end
        return res;
    endfunction

    // Comparator stride k of comparator level lv.
    function automatic int lvl_k(input int lv);
        int base;
        int res;
        base = 0;
        res  = 1;
        for (int x = 0; x < 8; x++) begin
            if (lv >= base && lv < base + x + 1) begin
                res = 1 << (x - (lv - base));
            end
            base = base + x + 1;
        end
        return res;
    endfunction

    logic          stall;
    logic [P-1:0]  padded;
    logic [P-1:0]  sorted;
    logic          sorted_vld;
    logic [CW-1:0] enc;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // Pad bits are tied low so they sort to the bottom and never reach the count.
    always_comb begin
        padded         = '0;
        padded[N-1:0]  = in_data;
    end

    genvar g;
    generate
        for (g = 0; g < D; g++) begin : g_lvl
            localparam int PP = lvl_p(g);
            localparam int KK = lvl_k(g);

            logic [P-1:0] d_in;
            logic         v_in;
            logic [P-1:0] nxt;
            logic [P-1:0] q;
            logic         v_q;

            if (g == 0) begin : g_first
                assign d_in = padded;
                assign v_in = in_valid;
            end else begin : g_chain
                assign d_in = g_lvl[g-1].q;
                assign v_in = g_lvl[g-1].v_q;
            end

            // One level of disjoint AND/OR comparators: AND to the lower index, OR to the upper.
            always_comb begin
                nxt = d_in;
                for (int j = KK % PP; j + KK < P; j += 2 * KK) begin
                    for (int i = 0; i < KK; i++) begin
                        if ((i + j + KK < P) && (((i + j) / (2 * PP)) == ((i + j + KK) / (2 * PP)))) begin
                            nxt[i + j]      = d_in[i + j] & d_in[i + j + KK];
                            nxt[i + j + KK] = d_in[i + j] | d_in[i + j + KK];
                        end
                    end
                end
            end

            if ((((g + 1) % REG_EVERY) == 0) || ((g + 1) == D)) begin : g_rank
                // Pipeline rank: data and its valid bit advance together unless stalled.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        q   <= '0;
                        v_q <= 1'b0;
                    end else if (!stall) begin
                        q   <= nxt;
                        v_q <= v_in;
                    end
                end
            end else begin : g_pass
                assign q   = nxt;
                assign v_q = v_in;
            end
        end
    endgenerate

    assign sorted     = g_lvl[D-1].q;
    assign sorted_vld = g_lvl[D-1].v_q;

    // Thermometer-to-binary: count is P minus the index of the lowest set bit.
    always_comb begin
        enc = '0;
        for (int i = P - 1; i >= 0; i--) begin
            if (sorted[i]) begin
                enc = CW'(P - i);
            end
        end
    end

    // Output register: holds its word while the consumer is not ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_count  <= '0;
`ifdef SN_PC_THERMO_EN
            out_thermo <= '0;
`endif
        end else if (!stall) begin
            out_valid  <= sorted_vld;
            out_count  <= enc;
`ifdef SN_PC_THERMO_EN
            out_thermo <= sorted[P-1:P-N];
`endif
        end
    end

endmodule
